board_state_store: RTL

- Owns the 64-square chess board register file.
- Accepts single-square write commands from the game-logic block: addr, piece, 1-cycle enable.
- Exports the whole board as a flat 256-bit bus back to game logic and to the renderer.
- Sequences new-game initialisation one square per cycle, tracks captures, and flags king capture (game over).

---
 rtl/chess_pkg.sv | 53 +++++
 rtl/board_state_store_if.sv | 12 +
 rtl/board_init_rom.sv | 11 +
 rtl/board_state_store.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings: piece types, colours, board geometry, FSM states,
// and the start-position lookup used by the initialisation sweep.
package chess_pkg;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    BISHOP = 3'd2,
    KNIGHT = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_type_e;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam int BOARD_SQUARES = 64;
  localparam int SQ_W          = 4;
  localparam int BOARD_W       = BOARD_SQUARES * SQ_W;
  localparam logic [2:0] LAST_ROW = 3'd7;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } store_state_e;

  // Square address is row*8+col; row 0 is the black back rank.
  function automatic logic [3:0] init_piece(input logic [5:0] addr);
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] back;
    logic [3:0] piece;
    row = addr[5:3];
    col = addr[2:0];
    case (col)
      3'd0, 3'd7: back = ROOK;
      3'd1, 3'd6: back = KNIGHT;
      3'd2, 3'd5: back = BISHOP;
      3'd3:       back = QUEEN;
      default:    back = KING;
    endcase
    case (row)
      3'd0:     piece = {BLACK, back};
      3'd1:     piece = {BLACK, 3'(PAWN)};
      3'd6:     piece = {WHITE, 3'(PAWN)};
      LAST_ROW: piece = {WHITE, back};
      default:  piece = {1'b0, 3'(EMPTY)};
    endcase
    return piece;
  endfunction

endpackage

// File: rtl/board_state_store_if.sv
// Square-write command bus from game logic into the board store.
interface board_state_store_if;
  // board_change_en is a single-cycle strobe with no backpressure: every high
  // cycle is one write of board_in_piece to board_in_addr; the store only
  // applies it while its ready output is high, otherwise write_dropped pulses.
  logic [5:0] board_in_addr;
  logic [3:0] board_in_piece;
  logic       board_change_en;

  modport master (output board_in_addr, output board_in_piece, output board_change_en);
  modport slave  (input  board_in_addr, input  board_in_piece, input  board_change_en);
endinterface

// File: rtl/board_init_rom.sv
// Combinational start-position lookup: square address to initial piece code.
module board_init_rom
  import chess_pkg::*;
(
  input  logic [5:0] addr,
  output logic [3:0] piece
);

  assign piece = init_piece(addr);

endmodule

// File: rtl/board_state_store.sv
// 64-square board register file with init sweep, capture tracking and king-capture
// detection. Optional: define BOARD_AUTO_PROMOTE_EN to store promoted pawns as queens.
module board_state_store
  import chess_pkg::*;
#(
  parameter int CAP_CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  board_state_store_if.slave   cmd,
  input  logic                 new_game,
  output logic [BOARD_W-1:0]   board_out,
  output logic                 ready,
  output logic                 is_in_initial_state,
  output logic                 write_dropped,
  output logic [3:0]           last_capture,
  output logic [CAP_CNT_W-1:0] white_captures,
  output logic [CAP_CNT_W-1:0] black_captures,
  output logic                 game_over,
  output logic                 winner,
  output store_state_e         dbg_state
);

  localparam logic [CAP_CNT_W-1:0] CAP_MAX = CAP_CNT_W'(16);

  logic [SQ_W-1:0] squares [BOARD_SQUARES];
  logic [5:0]      init_cnt;
  logic [3:0]      rom_piece;
  store_state_e    state, state_next;

  logic [3:0] old_piece;
  logic [3:0] new_piece;
  logic       accept;
  logic       capture;

  board_init_rom u_rom (
    .addr  (init_cnt),
    .piece (rom_piece)
  );

  assign dbg_state = state;

  for (genvar i = 0; i < BOARD_SQUARES; i++) begin : g_flat
    assign board_out[SQ_W*i +: SQ_W] = squares[i];
  end

  assign old_piece = squares[cmd.board_in_addr];

`ifdef BOARD_AUTO_PROMOTE_EN
  always_comb begin
    new_piece = cmd.board_in_piece;
    if (cmd.board_in_piece == {WHITE, 3'(PAWN)} && cmd.board_in_addr[5:3] == 3'd0)
      new_piece = {WHITE, 3'(QUEEN)};
    else if (cmd.board_in_piece == {BLACK, 3'(PAWN)} && cmd.board_in_addr[5:3] == LAST_ROW)
      new_piece = {BLACK, 3'(QUEEN)};
  end
`else
  assign new_piece = cmd.board_in_piece;
`endif

  // new_game outranks a simultaneous write strobe.
  assign accept  = (state == ST_READY) && cmd.board_change_en && !new_game;
  assign capture = (old_piece[2:0] != 3'(EMPTY)) && (new_piece[2:0] != 3'(EMPTY)) &&
                   (old_piece[3] != new_piece[3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (!new_game && init_cnt == 6'd63) state_next = ST_READY;
      ST_READY: if (new_game) state_next = ST_INIT;
      default:  state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BOARD_SQUARES; i++) squares[i] <= '0;
      init_cnt            <= '0;
      ready               <= 1'b0;
      is_in_initial_state <= 1'b0;
      write_dropped       <= 1'b0;
      last_capture        <= '0;
      white_captures      <= '0;
      black_captures      <= '0;
      game_over           <= 1'b0;
      winner              <= 1'b0;
    end else begin
      write_dropped <= 1'b0;
      case (state)
        ST_INIT: begin
          write_dropped <= cmd.board_change_en;
          if (new_game) begin
            init_cnt <= '0;
          end else begin
            squares[init_cnt] <= rom_piece;
            init_cnt          <= init_cnt + 6'd1;
            if (init_cnt == 6'd63) begin
              ready               <= 1'b1;
              is_in_initial_state <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (new_game) begin
            write_dropped       <= cmd.board_change_en;
            init_cnt            <= '0;
            ready               <= 1'b0;
            is_in_initial_state <= 1'b0;
            last_capture        <= '0;
            white_captures      <= '0;
            black_captures      <= '0;
            game_over           <= 1'b0;
            winner              <= 1'b0;
          end else if (accept) begin
            squares[cmd.board_in_addr] <= new_piece;
            if (new_piece != old_piece) is_in_initial_state <= 1'b0;
            if (capture) begin
              last_capture <= old_piece;
              if (new_piece[3] == WHITE) begin
                if (white_captures != CAP_MAX) white_captures <= white_captures + 1'b1;
              end else begin
                if (black_captures != CAP_MAX) black_captures <= black_captures + 1'b1;
              end
              // First king capture decides the game; later ones change nothing.
              if (old_piece[2:0] == 3'(KING) && !game_over) begin
                game_over <= 1'b1;
                winner    <= new_piece[3];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
